// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : nic8 program counter, instruction register and FETCH/EXEC phase
//            sequencing with run / single-step / halt-on-jump-to-self control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rom_data,
  input  logic [7:0]        bus,
  input  logic              uses_imm,
  input  logic              do_jump_bar,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        ir,
  output logic              fetch_en,
  output logic              exec_en,
  output logic              step_done,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [7:0]        ir_nx;
  logic              single, single_nx;
  logic              halted_nx;
  logic              step_done_nx;
  logic [CNT_W-1:0]  count_nx;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] opcode_addr;
  logic              halt_hit;

  assign jump_target = ADDR_W'(bus);
  // PC has already advanced past the opcode by the time EXEC runs
  assign opcode_addr = pc - ADDR_W'(1);
  assign halt_hit    = !do_jump_bar && (jump_target == opcode_addr);

  assign rom_addr = pc;
  assign fetch_en = (state == FETCH);
  assign exec_en  = (state == EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= 8'h00;
      single      <= 1'b0;
      halted      <= 1'b0;
      step_done   <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      ir          <= ir_nx;
      single      <= single_nx;
      halted      <= halted_nx;
      step_done   <= step_done_nx;
      instr_count <= count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    ir_nx        = ir;
    single_nx    = single;
    halted_nx    = halted;
    step_done_nx = 1'b0;
    count_nx     = instr_count;
    unique case (state)
      IDLE: begin
        if (!halted) begin
          if (run) begin
            state_nx  = FETCH;
            single_nx = 1'b0;
          end else if (step) begin
            state_nx  = FETCH;
            single_nx = 1'b1;
          end
        end
      end
      FETCH: begin
        ir_nx    = rom_data;
        pc_nx    = pc + ADDR_W'(1);
        state_nx = EXEC;
      end
      EXEC: begin
        if (!do_jump_bar) begin
          pc_nx = jump_target;
        end else if (uses_imm) begin
          pc_nx = pc + ADDR_W'(1);
        end
        if (instr_count != '1) begin
          count_nx = instr_count + CNT_W'(1);
        end
        // Halt outranks single-step completion and free-run
        if (halt_hit) begin
          halted_nx = 1'b1;
          single_nx = 1'b0;
          state_nx  = IDLE;
        end else if (single) begin
          step_done_nx = 1'b1;
          single_nx    = 1'b0;
          state_nx     = IDLE;
        end else if (run) begin
          state_nx = FETCH;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed plus randomized checking of fetch_sequencer against a
//            cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int AW   = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rom_data;
  logic [7:0]    bus;
  logic          uses_imm;
  logic          do_jump_bar;
  logic          run;
  logic          step;
  logic [AW-1:0] rom_addr;
  logic [7:0]    ir;
  logic          fetch_en;
  logic          exec_en;
  logic          step_done;
  logic          halted;
  logic [CW-1:0] instr_count;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rom_data   (rom_data),
    .bus        (bus),
    .uses_imm   (uses_imm),
    .do_jump_bar(do_jump_bar),
    .run        (run),
    .step       (step),
    .rom_addr   (rom_addr),
    .ir         (ir),
    .fetch_en   (fetch_en),
    .exec_en    (exec_en),
    .step_done  (step_done),
    .halted     (halted),
    .instr_count(instr_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1 = fetch, 2 = exec
  int m_phase, m_pc, m_ir, m_single, m_halted, m_count, m_sd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("rom_addr", rom_addr, m_pc);
    check_val("ir", ir, m_ir);
    check_val("fetch_en", fetch_en, m_phase == 1);
    check_val("exec_en", exec_en, m_phase == 2);
    check_val("step_done", step_done, m_sd);
    check_val("halted", halted, m_halted);
    check_val("instr_count", instr_count, m_count);
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_ir = 0; m_single = 0;
    m_halted = 0; m_count = 0; m_sd = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit jb, input bit imm, input int b);
    m_sd = 0;
    case (m_phase)
      0: if (m_halted == 0) begin
           if (r) begin m_phase = 1; m_single = 0; end
           else if (s) begin m_phase = 1; m_single = 1; end
         end
      1: begin
           m_ir = rom[m_pc];
           m_pc = (m_pc + 1) % 256;
           m_phase = 2;
         end
      default: begin
        int opcode;
        opcode = (m_pc + 255) % 256;
        if (m_count < CMAX) m_count = m_count + 1;
        if (!jb && b == opcode) begin
          m_halted = 1; m_single = 0; m_phase = 0; m_pc = b;
        end else begin
          if (!jb) m_pc = b;
          else if (imm) m_pc = (m_pc + 1) % 256;
          if (m_single != 0) begin m_sd = 1; m_single = 0; m_phase = 0; end
          else if (r) m_phase = 1;
          else m_phase = 0;
        end
      end
    endcase
  endtask

  // Called at a falling edge: drive, advance model, clock, check at next falling edge
  task automatic tick(input bit r, input bit s, input bit jb, input bit imm, input logic [7:0] b);
    run = r; step = s; do_jump_bar = jb; uses_imm = imm; bus = b;
    model_step(r, s, jb, imm, int'(b));
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_instr(input bit jb, input bit imm, input logic [7:0] b);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, jb, imm, b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; step = 1'b0; do_jump_bar = 1'b1; uses_imm = 1'b0; bus = 8'h00;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h12;
    rom[1] = 8'h34;
    reset = 1'b0;
    run = 1'b0; step = 1'b0; do_jump_bar = 1'b1; uses_imm = 1'b0; bus = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();

    // Free run from address 0
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    run_instr(1'b1, 1'b0, 8'h00);
    check_val("first_ir", ir, 8'h12);
    run_instr(1'b1, 1'b0, 8'h00);
    check_val("second_ir", ir, 8'h34);
    check_val("count_two", instr_count, 2);
    run_instr(1'b1, 1'b1, 8'h00);
    run_instr(1'b0, 1'b0, 8'h05);
    run_instr(1'b0, 1'b0, 8'h40);
    check_val("jump_target", rom_addr, 8'h40);
    check_val("no_halt", halted, 1'b0);

    // Jump-to-self at 0x10
    run_instr(1'b0, 1'b0, 8'h10);
    run_instr(1'b0, 1'b0, 8'h10);
    check_val("halt_set", halted, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_val("halt_idle", fetch_en, 1'b0);
    do_reset();

    // Single step with an ignored second pulse during EXEC
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_val("step_done_hi", step_done, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_val("step_done_lo", step_done, 1'b0);
    check_val("step_no_queue", fetch_en, 1'b0);

    // PC wrap from 0xFF
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    run_instr(1'b0, 1'b0, 8'hFF);
    run_instr(1'b1, 1'b0, 8'h00);
    check_val("pc_wrap", rom_addr, 8'h00);

    // Asynchronous reset while in EXEC
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check_val("in_exec", exec_en, 1'b1);
    do_reset();

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(63) == 0 || (m_halted != 0 && $urandom_range(7) == 0)) begin
        do_reset();
      end else begin
        bit r, s, jb, imm;
        logic [7:0] b;
        r   = ($urandom_range(3) != 0);
        s   = ($urandom_range(3) == 0);
        jb  = ($urandom_range(5) != 0);
        imm = 1'($urandom);
        b   = ($urandom_range(2) == 0) ? 8'((m_pc + 255) % 256) : 8'($urandom);
        tick(r, s, jb, imm, b);
      end
    end

    // Counter saturation
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < CMAX + 3; k++) run_instr(1'b1, 1'b0, 8'h00);
    check_val("count_sat", instr_count, CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
